// File: rtl/rx_sym_aligner.sv
// rx_sym_aligner -- per-channel programmable sample delay followed by
// decimation at a programmable phase.
//
// Every channel passes through a DEPTH-stage delay line that advances on
// each sam_clk strobe. The tap chosen by delay_sel (clamped to DEPTH) is
// sampled once per DECIM-sample window, at the phase held in ph_q, and
// presented on data_out with a one-cycle out_valid strobe. Data is passed
// bit-exact; there is no arithmetic on the sample path.
//
// Handshake: there is no back-pressure. data_in is consumed on every cycle
// in which sam_clk=1. out_valid=1 for exactly one cycle per emitted symbol,
// and data_out holds its value until the next strobe.
//
// Ports:
//   clk        system clock
//   reset      synchronous, active-low reset
//   sam_clk    sample-rate clock enable, one pulse per input sample
//   delay_sel  requested delay in samples (values > DEPTH clamp to DEPTH)
//   phase_sel  sample index within the symbol to emit (>= DECIM clamps)
//   data_in    CHANNELS signed samples, channel 0 in the LSBs
//   data_out   aligned, decimated symbols
//   out_valid  one-cycle strobe, data_out updated this cycle
//
// Optional build macro RX_SYM_ALIGNER_ENERGY_EN adds per-phase magnitude
// accumulators on channel 0 with ports:
//   clear_accum  zero all accumulators and acc_valid
//   best_phase   registered index of the largest accumulator (lowest on tie)
//   acc_valid    set after the first full window following clear or reset
module rx_sym_aligner #(
    parameter int WIDTH    = 18,
    parameter int CHANNELS = 2,
    parameter int DEPTH    = 8,
    parameter int DECIM    = 4,
    parameter int ACC_BITS = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         sam_clk,
    input  logic [$clog2(DEPTH+1)-1:0]   delay_sel,
    input  logic [$clog2(DECIM)-1:0]     phase_sel,
    input  logic [CHANNELS*WIDTH-1:0]    data_in,
    output logic [CHANNELS*WIDTH-1:0]    data_out,
    output logic                         out_valid
`ifdef RX_SYM_ALIGNER_ENERGY_EN
    ,
    input  logic                         clear_accum,
    output logic [$clog2(DECIM)-1:0]     best_phase,
    output logic                         acc_valid
`endif
);

    localparam int DSW = $clog2(DEPTH + 1);
    localparam int PSW = $clog2(DECIM);
    localparam int CW  = CHANNELS * WIDTH;
    localparam logic [PSW-1:0] LAST_PH = PSW'(DECIM - 1);

    if (DEPTH < 1 || DECIM < 2 || ACC_BITS < 0) begin : g_param_check
        $error("rx_sym_aligner: illegal parameter set");
    end

    logic [CW-1:0]  stage [1:DEPTH];
    logic [CW-1:0]  sel_sample;
    logic [DSW-1:0] sel_idx;
    logic [PSW-1:0] cnt;
    logic [PSW-1:0] ph_q;
    logic [PSW-1:0] ph_next;

    // delay_sel is applied live; tap 0 is the undelayed input.
    always_comb begin
        sel_idx    = (delay_sel > DSW'(DEPTH)) ? DSW'(DEPTH) : delay_sel;
        sel_sample = data_in;
        for (int k = 1; k <= DEPTH; k++) begin
            if (sel_idx == DSW'(k)) sel_sample = stage[k];
        end
    end

    // Compare one bit wider so DECIM itself is representable.
    always_comb begin
        ph_next = ({1'b0, phase_sel} >= (PSW+1)'(DECIM)) ? LAST_PH : phase_sel;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int k = 1; k <= DEPTH; k++) stage[k] <= '0;
        end else if (sam_clk) begin
            stage[1] <= data_in;
            for (int k = 2; k <= DEPTH; k++) stage[k] <= stage[k-1];
        end
    end

    // ph_q only changes at the window boundary, so a phase_sel change can
    // never produce zero or two outputs within one window.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt       <= '0;
            ph_q      <= '0;
            data_out  <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (sam_clk) begin
                if (cnt == LAST_PH) begin
                    cnt  <= '0;
                    ph_q <= ph_next;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                if (cnt == ph_q) begin
                    data_out  <= sel_sample;
                    out_valid <= 1'b1;
                end
            end
        end
    end

`ifdef RX_SYM_ALIGNER_ENERGY_EN
    localparam int AW = WIDTH + ACC_BITS;

    logic [AW-1:0]    acc [DECIM];
    logic [WIDTH-1:0] ch0;
    logic [WIDTH-1:0] mag;
    logic [AW:0]      sum;
    logic [PSW-1:0]   best_idx;
    logic [AW-1:0]    best_val;
    logic             win_started;

    // Magnitude of channel 0; the most negative code maps to the largest
    // positive code so the result always fits in WIDTH-1 bits.
    always_comb begin
        ch0 = sel_sample[WIDTH-1:0];
        mag = ch0;
        if (ch0[WIDTH-1]) begin
            if (ch0 == {1'b1, {(WIDTH-1){1'b0}}}) mag = {1'b0, {(WIDTH-1){1'b1}}};
            else                                   mag = -ch0;
        end
        sum = {1'b0, acc[cnt]} + (AW+1)'(mag);
    end

    // Strict '>' keeps the lowest index on ties.
    always_comb begin
        best_idx = '0;
        best_val = acc[0];
        for (int i = 1; i < DECIM; i++) begin
            if (acc[i] > best_val) begin
                best_val = acc[i];
                best_idx = PSW'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DECIM; i++) acc[i] <= '0;
            best_phase  <= '0;
            acc_valid   <= 1'b0;
            win_started <= 1'b0;
        end else begin
            best_phase <= best_idx;
            if (clear_accum) begin
                for (int i = 0; i < DECIM; i++) acc[i] <= '0;
                acc_valid   <= 1'b0;
                win_started <= 1'b0;
            end else if (sam_clk) begin
                acc[cnt] <= sum[AW] ? {AW{1'b1}} : sum[AW-1:0];
                if (cnt == '0) win_started <= 1'b1;
                if (cnt == LAST_PH && win_started) acc_valid <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_rx_sym_aligner.sv
// Directed bench for rx_sym_aligner (WIDTH=18, CHANNELS=2, DEPTH=8, DECIM=4).
module tb_rx_sym_aligner;

    localparam int W  = 18;
    localparam int CW = 2 * W;

    logic          clk = 1'b0;
    logic          reset;
    logic          sam_clk;
    logic [3:0]    delay_sel;
    logic [1:0]    phase_sel;
    logic [CW-1:0] data_in;
    logic [CW-1:0] data_out;
    logic          out_valid;
`ifdef RX_SYM_ALIGNER_ENERGY_EN
    logic          clear_accum;
    logic [1:0]    best_phase;
    logic          acc_valid;
`endif

    rx_sym_aligner #(
        .WIDTH(W), .CHANNELS(2), .DEPTH(8), .DECIM(4), .ACC_BITS(8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .sam_clk   (sam_clk),
        .delay_sel (delay_sel),
        .phase_sel (phase_sel),
        .data_in   (data_in),
        .data_out  (data_out),
        .out_valid (out_valid)
`ifdef RX_SYM_ALIGNER_ENERGY_EN
        ,
        .clear_accum (clear_accum),
        .best_phase  (best_phase),
        .acc_valid   (acc_valid)
`endif
    );

    always #5 clk = ~clk;

    int            n_err = 0;
    int            n_checks = 0;
    logic          exp_valid;
    logic [CW-1:0] exp_data;

    typedef struct {
        logic          sam;
        logic [CW-1:0] din;
        logic          ev;
        logic [CW-1:0] edata;
    } vec_t;

    vec_t tbl [16];

    function automatic logic [CW-1:0] pk(input int c0, input int c1);
        logic [W-1:0] x0;
        logic [W-1:0] x1;
        x0 = W'(c0);
        x1 = W'(c1);
        return {x1, x0};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample(input int c0, input int c1, input logic sam);
        data_in = pk(c0, c1);
        sam_clk = sam;
        tick();
    endtask

    // Expected data holds across non-valid cycles.
    task automatic expect_out(input logic ev, input int c0, input int c1);
        exp_valid = ev;
        if (ev) exp_data = pk(c0, c1);
    endtask

    task automatic check(input string nm);
        n_checks++;
        if (out_valid !== exp_valid) begin
            n_err++;
            $display("FAIL %s out_valid got %0b want %0b", nm, out_valid, exp_valid);
        end
        n_checks++;
        if (data_out !== exp_data) begin
            n_err++;
            $display("FAIL %s data_out got %h want %h", nm, data_out, exp_data);
        end
    endtask

    task automatic do_reset(input int n);
        reset   = 1'b0;
        sam_clk = 1'b1;
        data_in = pk(18'h1FFFF, 18'h1FFFF);
        repeat (n) tick();
        reset     = 1'b1;
        exp_valid = 1'b0;
        exp_data  = '0;
    endtask

    initial begin
        reset     = 1'b0;
        sam_clk   = 1'b0;
        delay_sel = '0;
        phase_sel = '0;
        data_in   = '0;
        exp_valid = 1'b0;
        exp_data  = '0;
`ifdef RX_SYM_ALIGNER_ENERGY_EN
        clear_accum = 1'b0;
`endif

        // Reset held with sam_clk active and all-ones input.
        sam_clk = 1'b1;
        data_in = pk(18'h1FFFF, 18'h1FFFF);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("reset_hold");
        end
        reset = 1'b1;

        // Bypass decimation, table driven.
        for (int i = 0; i < 16; i++) begin
            tbl[i].sam   = 1'b1;
            tbl[i].din   = pk(i, 7);
            tbl[i].ev    = ((i % 4) == 0);
            tbl[i].edata = pk(i, 7);
        end
        do_reset(1);
        delay_sel = 4'd0;
        phase_sel = 2'd0;
        for (int i = 0; i < 16; i++) begin
            data_in   = tbl[i].din;
            sam_clk   = tbl[i].sam;
            tick();
            exp_valid = tbl[i].ev;
            if (tbl[i].ev) exp_data = tbl[i].edata;
            check("bypass");
        end

        // Delay 3, phase 2 requested; ph_q is 0 until the first wrap.
        do_reset(1);
        delay_sel = 4'd3;
        phase_sel = 2'd2;
        for (int s = 0; s < 16; s++) begin
            sample(s, -s, 1'b1);
            if (s == 0)                        expect_out(1'b1, 0, 0);
            else if (s >= 4 && (s % 4) == 2)   expect_out(1'b1, s - 3, -(s - 3));
            else                               expect_out(1'b0, 0, 0);
            check("delay_phase");
            for (int g = 0; g < 2; g++) begin
                sample(12345, -999, 1'b0);
                expect_out(1'b0, 0, 0);
                check("delay_phase_idle");
            end
        end

        // delay_sel above DEPTH clamps to tap 8.
        do_reset(1);
        delay_sel = 4'd12;
        phase_sel = 2'd0;
        for (int s = 0; s < 20; s++) begin
            sample(s + 1, -(s + 1), 1'b1);
            if ((s % 4) == 0) begin
                if (s >= 8) expect_out(1'b1, s - 7, -(s - 7));
                else        expect_out(1'b1, 0, 0);
            end else begin
                expect_out(1'b0, 0, 0);
            end
            check("clamp");
        end

        // Phase change mid-window takes effect after the next wrap.
        do_reset(1);
        delay_sel = 4'd0;
        phase_sel = 2'd0;
        for (int s = 0; s < 16; s++) begin
            if (s == 2) phase_sel = 2'd3;
            sample(s, 0, 1'b1);
            expect_out((s == 0) || (s >= 4 && (s % 4) == 3), s, 0);
            check("phase_change");
        end

        // Reset asserted on the cycle an output would fire.
        do_reset(1);
        delay_sel = 4'd2;
        phase_sel = 2'd1;
        for (int s = 0; s < 9; s++) begin
            sample(s + 1, 0, 1'b1);
            if (s == 0)      expect_out(1'b1, 0, 0);
            else if (s == 5) expect_out(1'b1, s - 1, 0);
            else             expect_out(1'b0, 0, 0);
            check("pre_reset");
        end
        reset = 1'b0;
        sample(10, 0, 1'b1);
        reset     = 1'b1;
        exp_valid = 1'b0;
        exp_data  = '0;
        check("reset_mid");
        for (int t = 0; t < 8; t++) begin
            sample(100 + t, 0, 1'b1);
            if (t == 0)      expect_out(1'b1, 0, 0);
            else if (t == 5) expect_out(1'b1, 103, 0);
            else             expect_out(1'b0, 0, 0);
            check("post_reset");
        end

`ifdef RX_SYM_ALIGNER_ENERGY_EN
        do_reset(1);
        delay_sel = 4'd0;
        phase_sel = 2'd0;
        for (int s = 0; s < 4; s++) sample(((s % 4) == 2) ? 100 : 0, 0, 1'b1);
        n_checks++;
        if (acc_valid !== 1'b1) begin
            n_err++;
            $display("FAIL energy_valid acc_valid got %0b want 1", acc_valid);
        end
        n_checks++;
        if (best_phase !== 2'd2) begin
            n_err++;
            $display("FAIL energy_best best_phase got %0d want 2", best_phase);
        end
        clear_accum = 1'b1;
        sam_clk     = 1'b0;
        tick();
        clear_accum = 1'b0;
        tick();
        n_checks++;
        if (acc_valid !== 1'b0) begin
            n_err++;
            $display("FAIL energy_clear acc_valid got %0b want 0", acc_valid);
        end
        n_checks++;
        if (best_phase !== 2'd0) begin
            n_err++;
            $display("FAIL energy_clear_best best_phase got %0d want 0", best_phase);
        end
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/rx_sym_aligner.md
Name: rx_sym_aligner

Overview:
- Parametrised, multi-channel successor to the receiver's fixed four-tap alignment delay and divide-by-4 symbol pick.
- Sits after the receive matched filter at sample rate. Delays every channel by a run-time-selected number of samples (0..DEPTH), then decimates by DECIM at a programmable phase.
- Emits one aligned symbol per channel per DECIM samples, with a valid strobe.

Parameters:
WIDTH, 18, signed sample width per channel
CHANNELS, 2, number of parallel channels (e.g. I and Q), packed channel 0 in LSBs
DEPTH, 8, maximum selectable delay in samples (>=1)
DECIM, 4, decimation ratio, samples per symbol (>=2)
ACC_BITS, 8, extra accumulator headroom bits (used only with optional feature)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset
sam_clk  in  1  sample-rate clock enable, one-cycle pulse per input sample
delay_sel  in  clog2(DEPTH+1)  requested delay in samples
phase_sel  in  clog2(DECIM)  sample index within symbol to output
data_in  in  CHANNELS*WIDTH  signed samples, valid when sam_clk=1
data_out  out  CHANNELS*WIDTH  aligned decimated symbols
out_valid  out  1  one-cycle strobe, data_out updated this cycle

Behaviour:
- Reset: when reset=0 at posedge clk, clear:
  - all delay stages, data_out, out_valid and the phase counter to 0;
  - the phase_sel shadow register to 0.
  - Reset overrides sam_clk.
- Delay line:
  - Per channel, DEPTH registers stage[1..DEPTH]; tap[0] = data_in, tap[k] = stage[k].
  - On sam_clk=1: stage[1] <= data_in, stage[k] <= stage[k-1]. Without sam_clk, hold.
  - Selected sample = tap[min(delay_sel, DEPTH)]; delay_sel > DEPTH clamps to DEPTH.
  - delay_sel is used live: no shadowing, no glitch protection.
- Phase counter cnt:
  - Advances 0..DECIM-1 on each sam_clk, wraps DECIM-1 -> 0.
  - Holds when sam_clk=0.
- Phase shadow ph_q:
  - Loaded from phase_sel only on sam_clk with cnt==DECIM-1, and at reset (to 0).
  - phase_sel values >= DECIM clamp to DECIM-1.
  - This guarantees exactly one output per DECIM-sample window.
- Output:
  - On posedge with sam_clk=1 and cnt==ph_q: data_out <= selected sample (all channels); out_valid <= 1.
  - Otherwise data_out holds and out_valid <= 0.
- Latency:
  - Sample on data_in at the capturing edge with delay_sel=0 appears on data_out one clk later.
  - With delay_sel=k, data_out reflects the input from k sam_clk strobes earlier.
- No arithmetic on the data path; values pass bit-exact, sign preserved.
- sam_clk held high every cycle is legal (full-rate). out_valid is then high 1 of every DECIM cycles.

Optional Feature:
- Macro RX_SYM_ALIGNER_ENERGY_EN.
- Defined, adds ports:
  - clear_accum  in  1
  - best_phase  out  clog2(DECIM)
  - acc_valid  out  1
- Behaviour when defined:
  - DECIM accumulators of width WIDTH+ACC_BITS, unsigned.
  - On each sam_clk, acc[cnt] += |channel 0 of delayed-selected sample|. |most-negative| = 2^(WIDTH-1)-1. Each accumulator saturates at all-ones.
  - clear_accum=1 zeroes all accumulators and acc_valid (priority over accumulate).
  - best_phase is registered and updates each cycle to the argmax index; ties resolve to the lowest index.
  - acc_valid goes 1 after the first full DECIM-sample window following clear or reset.
  - Reset clears all of these.
- Undefined: ports and logic are absent; the core behaviour above is identical.

Test Plan:
- Reset: hold reset=0 for 3 clks with sam_clk=1 and data_in=0x1FFFF -> data_out=0, out_valid=0, cnt=0 after release.
- Bypass decimation: delay_sel=0, phase_sel=0, sam_clk every cycle, ch0 ramp 0,1,2,… -> out_valid on every 4th cycle, ch0 outputs 0,4,8,12.
- Delay plus phase:
  - Setup: delay_sel=3, phase_sel=2, sam_clk every 3rd cycle, ch0 ramp 0,1,2,…, ch1 = -ch0.
  - Required outputs: ch0 = -1?… no — ch0 = 0 (pipeline-fill zero), 3, 7, 11. ch1 = 0, -3, -7, -11 (18-bit signed).
- Clamp and phase change:
  - delay_sel=12 with DEPTH=8 behaves exactly as delay_sel=8.
  - Switching phase_sel 0->3 mid-window still yields exactly one out_valid per 4 samples. The new phase takes effect after the next wrap.
- Reset mid-operation: assert reset=0 for 1 clk while out_valid would fire -> out_valid=0, data_out=0. The next output comes at phase ph_q=0 of the new window, with delay-stage zeros flushing out first.
- Energy (RX_SYM_ALIGNER_ENERGY_EN):
  - ch0 pattern 0,0,100,0 repeating, DECIM=4, delay_sel=0 -> best_phase=2 and acc_valid=1 after the first window.
  - clear_accum=1 -> accumulators 0, acc_valid=0.
  - Saturation holds at all-ones.
